// File: rtl/hazard_control_unit.sv
// Hazard controller for the ID-stage bypass network: load-use bubbles, redirect flushes,
// multi-cycle MUL/DIV freezes and debug halt drain/freeze, plus a saturating stall counter.
module hazard_control_unit #(
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 4,
    parameter int MD_TIMEOUT   = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       rs1_id_i,
    input  logic [4:0]       rs2_id_i,
    input  logic             uses_rs1_id_i,
    input  logic             uses_rs2_id_i,
    input  logic             mem_read_ex_i,
    input  logic [4:0]       rd_ex_i,
    input  logic             redirect_ex_i,
    input  logic             muldiv_start_ex_i,
    input  logic             muldiv_done_i,
    input  logic             halt_req_i,
    input  logic             resume_i,
    output logic             stall_if_o,
    output logic             stall_id_o,
    output logic             stall_ex_o,
    output logic             flush_id_o,
    output logic             flush_ex_o,
    output logic             flush_mem_o,
    output logic             halt_ack_o,
    output logic             muldiv_timeout_o,
    output logic [CNT_W-1:0] stall_count_o
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam int MW = $clog2(MD_TIMEOUT + 2);

    typedef enum logic [1:0] {RUN, MD_WAIT, DRAIN, HALTED} state_e;

    state_e           state_q, state_d;
    logic             haltPend_q, haltPend_d;
    logic [DW-1:0]    drainCnt_q, drainCnt_d;
    logic [MW-1:0]    mdCnt_q, mdCnt_d;
    logic             mdTimeout_q, mdTimeout_d;
    logic             haltAck_q;
    logic [CNT_W-1:0] stallCount_q;
    logic             loadUse;
    logic             mdStall;

    assign loadUse = mem_read_ex_i && (rd_ex_i != 5'd0) &&
                     ((uses_rs1_id_i && (rd_ex_i == rs1_id_i)) ||
                      (uses_rs2_id_i && (rd_ex_i == rs2_id_i)));
    assign mdStall = muldiv_start_ex_i && !muldiv_done_i;

    always_comb begin
        stall_if_o  = 1'b0;
        stall_id_o  = 1'b0;
        stall_ex_o  = 1'b0;
        flush_id_o  = 1'b0;
        flush_ex_o  = 1'b0;
        flush_mem_o = 1'b0;
        state_d     = state_q;
        haltPend_d  = haltPend_q;
        drainCnt_d  = drainCnt_q;
        mdCnt_d     = mdCnt_q;
        mdTimeout_d = mdTimeout_q;

        case (state_q)
            RUN, DRAIN: begin
                if (redirect_ex_i) begin
                    flush_id_o = 1'b1;
                    flush_ex_o = 1'b1;
                    if (state_q == DRAIN) begin
                        drainCnt_d = '0;
                    end
                end else if (mdStall) begin
                    stall_if_o  = 1'b1;
                    stall_id_o  = 1'b1;
                    stall_ex_o  = 1'b1;
                    flush_mem_o = 1'b1;
                    state_d     = MD_WAIT;
                    mdCnt_d     = MW'(1);
                end else if (!muldiv_start_ex_i && loadUse) begin
                    stall_if_o = 1'b1;
                    stall_id_o = 1'b1;
                    flush_ex_o = 1'b1;
                end else if (state_q == RUN) begin
                    if (halt_req_i || haltPend_q) begin
                        haltPend_d = 1'b1;
                        state_d    = DRAIN;
                        drainCnt_d = '0;
                    end
                end else if (drainCnt_q == DW'(DRAIN_CYCLES - 1)) begin
                    state_d = HALTED;
                end else begin
                    drainCnt_d = drainCnt_q + DW'(1);
                end
                // Draining keeps fetch frozen and feeds bubbles regardless of any event.
                if (state_q == DRAIN) begin
                    stall_if_o = 1'b1;
                    flush_id_o = 1'b1;
                end
            end
            MD_WAIT: begin
                if (muldiv_done_i) begin
                    state_d = RUN;
                end else begin
                    stall_if_o  = 1'b1;
                    stall_id_o  = 1'b1;
                    stall_ex_o  = 1'b1;
                    flush_mem_o = 1'b1;
                    mdCnt_d     = mdCnt_q + MW'(1);
                    if (mdCnt_q == MW'(MD_TIMEOUT)) begin
                        mdTimeout_d = 1'b1;
                        state_d     = RUN;
                    end
                end
            end
            HALTED: begin
                stall_if_o  = 1'b1;
                stall_id_o  = 1'b1;
                stall_ex_o  = 1'b1;
                flush_mem_o = 1'b1;
                if (resume_i && !halt_req_i) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        if (state_d == HALTED) begin
            haltPend_d = 1'b0;
        end
    end

    // halt_ack follows the next state so it is already high in the first HALTED cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= RUN;
            haltPend_q   <= 1'b0;
            drainCnt_q   <= '0;
            mdCnt_q      <= '0;
            mdTimeout_q  <= 1'b0;
            haltAck_q    <= 1'b0;
            stallCount_q <= '0;
        end else begin
            state_q     <= state_d;
            haltPend_q  <= haltPend_d;
            drainCnt_q  <= drainCnt_d;
            mdCnt_q     <= mdCnt_d;
            mdTimeout_q <= mdTimeout_d;
            haltAck_q   <= (state_d == HALTED);
            if (stall_if_o && (state_q != HALTED) && (stallCount_q != '1)) begin
                stallCount_q <= stallCount_q + CNT_W'(1);
            end
        end
    end

    assign halt_ack_o       = haltAck_q;
    assign muldiv_timeout_o = mdTimeout_q;
    assign stall_count_o    = stallCount_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit: inputs change on the falling edge,
// outputs are checked 1 time unit later, well away from the rising edge.
module tb_hazard_control_unit;

    localparam logic [5:0] CTL_NONE      = 6'b000_000;
    localparam logic [5:0] CTL_LUH       = 6'b110_010;
    localparam logic [5:0] CTL_REDIR     = 6'b000_110;
    localparam logic [5:0] CTL_FREEZE    = 6'b111_001;
    localparam logic [5:0] CTL_DRAIN     = 6'b100_100;
    localparam logic [5:0] CTL_DRAIN_LUH = 6'b110_110;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [4:0]  rs1_id_i, rs2_id_i, rd_ex_i;
    logic        uses_rs1_id_i, uses_rs2_id_i, mem_read_ex_i;
    logic        redirect_ex_i, muldiv_start_ex_i, muldiv_done_i;
    logic        halt_req_i, resume_i;
    logic        stall_if_o, stall_id_o, stall_ex_o;
    logic        flush_id_o, flush_ex_o, flush_mem_o;
    logic        halt_ack_o, muldiv_timeout_o;
    logic [31:0] stall_count_o;
    logic [5:0]  ctl;

    int assertCount = 0;
    int failCount   = 0;

    hazard_control_unit #(
        .CNT_W(32), .DRAIN_CYCLES(4), .MD_TIMEOUT(64)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rs1_id_i(rs1_id_i), .rs2_id_i(rs2_id_i),
        .uses_rs1_id_i(uses_rs1_id_i), .uses_rs2_id_i(uses_rs2_id_i),
        .mem_read_ex_i(mem_read_ex_i), .rd_ex_i(rd_ex_i),
        .redirect_ex_i(redirect_ex_i), .muldiv_start_ex_i(muldiv_start_ex_i),
        .muldiv_done_i(muldiv_done_i), .halt_req_i(halt_req_i), .resume_i(resume_i),
        .stall_if_o(stall_if_o), .stall_id_o(stall_id_o), .stall_ex_o(stall_ex_o),
        .flush_id_o(flush_id_o), .flush_ex_o(flush_ex_o), .flush_mem_o(flush_mem_o),
        .halt_ack_o(halt_ack_o), .muldiv_timeout_o(muldiv_timeout_o),
        .stall_count_o(stall_count_o)
    );

    always #5 clk_i = ~clk_i;

    assign ctl = {stall_if_o, stall_id_o, stall_ex_o, flush_id_o, flush_ex_o, flush_mem_o};

    // Single comparison point: counts every check and reports any disagreement.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkCtl(input string tag, input logic [5:0] expected);
        checkOutput(tag, 32'(ctl), 32'(expected));
    endtask

    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic memRd,
                                 input logic [4:0] rdEx, input logic redir,
                                 input logic mdStart, input logic mdDone,
                                 input logic haltReq, input logic resume);
        @(negedge clk_i);
        rs1_id_i          = rs1;
        rs2_id_i          = rs2;
        uses_rs1_id_i     = u1;
        uses_rs2_id_i     = u2;
        mem_read_ex_i     = memRd;
        rd_ex_i           = rdEx;
        redirect_ex_i     = redir;
        muldiv_start_ex_i = mdStart;
        muldiv_done_i     = mdDone;
        halt_req_i        = haltReq;
        resume_i          = resume;
        #1;
    endtask

    task automatic idleCycle(input logic haltReq, input logic resume);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, haltReq, resume);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_ni = 1'b0;
        rs1_id_i = '0; rs2_id_i = '0; rd_ex_i = '0;
        uses_rs1_id_i = 0; uses_rs2_id_i = 0; mem_read_ex_i = 0;
        redirect_ex_i = 0; muldiv_start_ex_i = 0; muldiv_done_i = 0;
        halt_req_i = 0; resume_i = 0;
        @(negedge clk_i);
        #1;
        checkCtl("reset_ctl", CTL_NONE);
        checkOutput("reset_ack", 32'(halt_ack_o), 32'd0);
        checkOutput("reset_timeout", 32'(muldiv_timeout_o), 32'd0);
        checkOutput("reset_count", stall_count_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Load x5 in EX, ID reads x5 through rs2
        applyStimulus(5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCtl("luh_rs2", CTL_LUH);
        idleCycle(1'b0, 1'b0);
        checkCtl("luh_after", CTL_NONE);
        checkOutput("luh_count", stall_count_o, 32'd1);

        // No hazard: load into x0, or rs2 not used
        applyStimulus(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCtl("luh_x0", CTL_NONE);
        applyStimulus(5'd3, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCtl("luh_rs2_unused", CTL_NONE);

        // Redirect beats load-use
        applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCtl("redirect_over_luh", CTL_REDIR);
        idleCycle(1'b0, 1'b0);
        checkOutput("redirect_count", stall_count_o, 32'd1);

        // MUL/DIV finishing 5 cycles after issue
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkCtl("md_start", CTL_FREEZE);
        for (int i = 0; i < 4; i++) begin
            idleCycle(1'b0, 1'b0);
            checkCtl("md_wait", CTL_FREEZE);
        end
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkCtl("md_done", CTL_NONE);
        idleCycle(1'b0, 1'b0);
        checkCtl("md_after", CTL_NONE);
        checkOutput("md_count", stall_count_o, 32'd6);
        applyStimulus(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCtl("md_back_in_run", CTL_LUH);
        idleCycle(1'b0, 1'b0);
        checkOutput("md_luh_count", stall_count_o, 32'd7);

        // MUL/DIV that never completes
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkCtl("to_start", CTL_FREEZE);
        for (int i = 0; i < 64; i++) begin
            idleCycle(1'b0, 1'b0);
            checkCtl("to_wait", CTL_FREEZE);
            checkOutput("to_flag_low", 32'(muldiv_timeout_o), 32'd0);
        end
        idleCycle(1'b0, 1'b0);
        checkCtl("to_back_in_run", CTL_NONE);
        checkOutput("to_flag_set", 32'(muldiv_timeout_o), 32'd1);
        checkOutput("to_count", stall_count_o, 32'd72);

        // Debug halt with no hazards
        idleCycle(1'b1, 1'b0);
        checkCtl("halt_run", CTL_NONE);
        for (int i = 0; i < 4; i++) begin
            idleCycle(1'b1, 1'b0);
            checkCtl("halt_drain", CTL_DRAIN);
            checkOutput("halt_drain_ack", 32'(halt_ack_o), 32'd0);
        end
        idleCycle(1'b1, 1'b0);
        checkCtl("halted", CTL_FREEZE);
        checkOutput("halted_ack", 32'(halt_ack_o), 32'd1);
        checkOutput("halted_count", stall_count_o, 32'd76);
        idleCycle(1'b1, 1'b1);
        checkOutput("resume_held_ack", 32'(halt_ack_o), 32'd1);
        idleCycle(1'b0, 1'b0);
        checkCtl("resume_ignored", CTL_FREEZE);
        checkOutput("resume_ignored_ack", 32'(halt_ack_o), 32'd1);
        idleCycle(1'b0, 1'b1);
        checkCtl("resume_cycle", CTL_FREEZE);
        idleCycle(1'b0, 1'b0);
        checkCtl("resumed", CTL_NONE);
        checkOutput("resumed_ack", 32'(halt_ack_o), 32'd0);
        checkOutput("resumed_count", stall_count_o, 32'd76);

        // Halt with a load-use in the second drain cycle
        idleCycle(1'b1, 1'b0);
        checkCtl("halt2_run", CTL_NONE);
        idleCycle(1'b1, 1'b0);
        checkCtl("halt2_drain1", CTL_DRAIN);
        applyStimulus(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCtl("halt2_drain_luh", CTL_DRAIN_LUH);
        for (int i = 0; i < 3; i++) begin
            idleCycle(1'b1, 1'b0);
            checkCtl("halt2_drain", CTL_DRAIN);
            checkOutput("halt2_drain_ack", 32'(halt_ack_o), 32'd0);
        end
        idleCycle(1'b1, 1'b0);
        checkCtl("halt2_halted", CTL_FREEZE);
        checkOutput("halt2_ack", 32'(halt_ack_o), 32'd1);
        checkOutput("halt2_count", stall_count_o, 32'd81);
        idleCycle(1'b0, 1'b1);
        idleCycle(1'b0, 1'b0);
        checkCtl("halt2_resumed", CTL_NONE);
        checkOutput("timeout_sticky", 32'(muldiv_timeout_o), 32'd1);

        // Reset while waiting on MUL/DIV
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idleCycle(1'b0, 1'b0);
        checkCtl("rst_pre_md_wait", CTL_FREEZE);
        rst_ni = 1'b0;
        #1;
        checkCtl("rst_mid_ctl", CTL_NONE);
        checkOutput("rst_mid_timeout", 32'(muldiv_timeout_o), 32'd0);
        checkOutput("rst_mid_count", stall_count_o, 32'd0);
        checkOutput("rst_mid_ack", 32'(halt_ack_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        idleCycle(1'b0, 1'b0);
        checkCtl("rst_after_ctl", CTL_NONE);
        checkOutput("rst_after_count", stall_count_o, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline controller that sequences the ID-stage operand bypass network.
- Covers the hazards forwarding cannot resolve:
  - load-use, by inserting a 1-cycle bubble;
  - taken branch/jump redirect, by flushing the wrong-path instructions;
  - multi-cycle MUL/DIV in EX, by freezing the front end;
  - debug halt, by draining the pipeline and then freezing it.
- Drives the stall/flush controls of the PC, IF/ID, ID/EX and EX/MEM registers.

Parameters:
- CNT_W, 32, width of the saturating stall-cycle counter.
- DRAIN_CYCLES, 4, number of counted drain cycles before HALTED (empties ID, EX, MEM, WB).
- MD_TIMEOUT, 64, maximum number of MD_WAIT cycles before the timeout error.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- rs1_id_i  in  5  rs1 of the instruction in ID.
- rs2_id_i  in  5  rs2 of the instruction in ID.
- uses_rs1_id_i  in  1  ID instruction reads rs1.
- uses_rs2_id_i  in  1  ID instruction reads rs2.
- mem_read_ex_i  in  1  EX instruction is a load.
- rd_ex_i  in  5  destination register of the EX instruction.
- redirect_ex_i  in  1  taken branch/jump resolved in EX.
- muldiv_start_ex_i  in  1  multi-cycle MUL/DIV is issuing in EX.
- muldiv_done_i  in  1  MUL/DIV result valid this cycle.
- halt_req_i  in  1  debug halt request, level.
- resume_i  in  1  debug resume, sampled only in HALTED.
- stall_if_o  out  1  hold the PC.
- stall_id_o  out  1  hold IF/ID.
- stall_ex_o  out  1  hold ID/EX.
- flush_id_o  out  1  bubble into IF/ID.
- flush_ex_o  out  1  bubble into ID/EX.
- flush_mem_o  out  1  bubble into EX/MEM.
- halt_ack_o  out  1  pipeline halted.
- muldiv_timeout_o  out  1  sticky error flag.
- stall_count_o  out  CNT_W  saturating count of stall cycles.

Behaviour:
Outputs and reset
- Stall/flush outputs are combinational from state and current inputs.
- halt_ack_o, muldiv_timeout_o and stall_count_o are registered.
- Reset (async assert, sync release): state=RUN, halt_pend=0, drain_cnt=0, md_cnt=0, all outputs 0.

Load-use hazard
- luh = mem_read_ex_i & (rd_ex_i!=0) & ((uses_rs1_id_i & rd_ex_i==rs1_id_i) | (uses_rs2_id_i & rd_ex_i==rs2_id_i)).

State machine: RUN, MD_WAIT, DRAIN, HALTED

RUN and DRAIN share the event rules below. Priority is redirect > muldiv > luh.
- redirect_ex_i: flush_id=1, flush_ex=1, no stall. Any muldiv_start/luh in the same cycle is ignored.
- muldiv_start_ex_i & !muldiv_done_i: stall_if=stall_id=stall_ex=1, flush_mem=1; next state MD_WAIT, md_cnt=1.
- muldiv_start_ex_i & muldiv_done_i: no action (single-cycle result).
- luh: stall_if=stall_id=1, flush_ex=1 for exactly one cycle; the load then sits in MEM and is forwarded.

RUN only
- halt_req_i (or halt_pend) with no event above: set halt_pend; next state DRAIN, drain_cnt=0.

DRAIN only
- stall_if=1 and flush_id=1 are additionally forced every cycle (ORed with the event outputs).
- drain_cnt increments only on cycles with no redirect, muldiv or luh action.
- A redirect restarts drain_cnt at 0.
- When drain_cnt==DRAIN_CYCLES-1 on a counted cycle: next state HALTED.
- A muldiv start goes to MD_WAIT; halt_pend stays set, so RUN re-enters DRAIN afterwards.

MD_WAIT
- stall_if=stall_id=stall_ex=1, flush_mem=1 every cycle; md_cnt increments.
- muldiv_done_i: all outputs 0 that cycle (result captured into EX/MEM); next state RUN.
- md_cnt==MD_TIMEOUT without done: set muldiv_timeout_o (sticky until reset); next state RUN.
- redirect/luh inputs are ignored in this state.

HALTED
- stall_if=stall_id=stall_ex=1, flush_mem=1.
- halt_ack_o=1 from the first HALTED cycle; halt_pend cleared on entry.
- resume_i & !halt_req_i: next state RUN, halt_ack_o=0 the following cycle.
- resume_i while halt_req_i=1 is ignored.

stall_count_o
- +1 on every cycle with stall_if_o=1 and state!=HALTED.
- Saturates at 2^CNT_W-1.

Reset mid-operation
- Any state returns immediately to RUN with all outputs 0; the counter and the timeout flag are cleared.

Test Plan:
- Load x5 in EX, ID reads rs2=x5 (uses_rs2=1) -> one cycle with stall_if=stall_id=flush_ex=1; next cycle all 0; stall_count=1.
- Same, but rd_ex=x0 or uses_rs2=0 -> no stall.
- Load-use and redirect_ex_i in the same cycle -> flush_id=flush_ex=1, stall_if=0.
- muldiv_start, done 5 cycles later -> stalls+flush_mem high for 5 cycles, low on the done cycle; state RUN; stall_count=5.
- muldiv_start, done never arrives -> muldiv_timeout_o=1 after 64 MD_WAIT cycles, state RUN; flag stays 1 until rst_ni=0.
- halt_req_i=1 in RUN, no hazards -> 4 DRAIN cycles (stall_if=flush_id=1), then halt_ack_o=1; resume_i with halt_req=1 ignored; drop halt_req, pulse resume -> RUN, halt_ack=0.
- Load-use during DRAIN cycle 2 -> drain extended by 1 (HALTED after 5 DRAIN cycles).
- rst_ni low in MD_WAIT -> all outputs 0 immediately.
